// File: rtl/frame_cfg_pkg.sv
// Shared state encoding and header field positions for the frame strobe sequencer.
package frame_cfg_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SETUP,
      STROBE,
      HOLD
   } state_t;

   localparam int unsigned HDR_COL_MSB = 15;
   localparam int unsigned HDR_COL_LSB = 8;
   localparam int unsigned HDR_FRM_MSB = 7;
   localparam int unsigned HDR_FRM_LSB = 0;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Registered one-hot decode of (column, frame) onto the flat FrameStrobe vector.
module frame_strobe_decoder #(
   parameter int unsigned MaxFramesPerCol = 20,
   parameter int unsigned NumColumns      = 8
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [7:0]                            col,
   input  logic [7:0]                            frame,
   input  logic                                  en,
   output logic [NumColumns*MaxFramesPerCol-1:0] strobe
);

   localparam int unsigned STROBE_W = NumColumns * MaxFramesPerCol;

   int unsigned         idx;
   logic [STROBE_W-1:0] strobe_n;

   always_comb begin
      idx      = 32'(col) * MaxFramesPerCol + 32'(frame);
      strobe_n = '0;
      if (en) begin
         strobe_n = STROBE_W'(1) << idx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         strobe <= '0;
      end else begin
         strobe <= strobe_n;
      end
   end

endmodule

// File: rtl/frame_strobe_sequencer.sv
// Assembles {header, NumRows words} into FrameData and pulses one FrameStrobe bit.
// Optional 16-bit frame_count output enabled by CONFIG_FRAME_COUNT_EN.
module frame_strobe_sequencer
   import frame_cfg_pkg::*;
#(
   parameter int unsigned MaxFramesPerCol = 20,
   parameter int unsigned FrameBitsPerRow = 32,
   parameter int unsigned NumRows         = 4,
   parameter int unsigned NumColumns      = 8,
   parameter int unsigned StrobeCycles    = 2
) (
   input  logic                                  UserCLK,
   input  logic                                  Reset,
   input  logic [FrameBitsPerRow-1:0]            s_data,
   input  logic                                  s_valid,
   output logic                                  s_ready,
   output logic [FrameBitsPerRow*NumRows-1:0]    FrameData,
   output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
   output logic                                  busy,
   output logic                                  err,
   input  logic                                  err_clr
`ifdef CONFIG_FRAME_COUNT_EN
   ,
   output logic [15:0]                           frame_count
`endif
);

   localparam int unsigned DATA_W = FrameBitsPerRow * NumRows;
   localparam int unsigned PTR_W  = (NumRows > 1) ? $clog2(NumRows) : 1;
   localparam int unsigned CNT_W  = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;

   state_t              state, state_n;
   logic [PTR_W-1:0]    ptr, ptr_n;
   logic [CNT_W-1:0]    cnt, cnt_n;
   logic [7:0]          col, col_n;
   logic [7:0]          frm, frm_n;
   logic                discard, discard_n;
   logic                err_n;
   logic [DATA_W-1:0]   data_n;
   logic [7:0]          hdr_col, hdr_frm;
   logic                hdr_bad;
   logic                strobe_en;

   assign hdr_col   = s_data[HDR_COL_MSB:HDR_COL_LSB];
   assign hdr_frm   = s_data[HDR_FRM_MSB:HDR_FRM_LSB];
   assign hdr_bad   = (32'(hdr_col) >= NumColumns) || (32'(hdr_frm) >= MaxFramesPerCol);
   assign strobe_en = (state_n == STROBE);

   // Next-state and datapath update; a set of err on a bad header wins over err_clr.
   always_comb begin
      state_n   = state;
      ptr_n     = ptr;
      cnt_n     = cnt;
      col_n     = col;
      frm_n     = frm;
      discard_n = discard;
      data_n    = FrameData;
      err_n     = err & ~err_clr;
      case (state)
         IDLE: begin
            if (s_valid) begin
               state_n   = LOAD;
               ptr_n     = '0;
               col_n     = hdr_col;
               frm_n     = hdr_frm;
               discard_n = hdr_bad;
               if (hdr_bad) begin
                  err_n = 1'b1;
               end
            end
         end
         LOAD: begin
            if (s_valid) begin
               for (int unsigned r = 0; r < NumRows; r++) begin
                  if (!discard && ptr == PTR_W'(r)) begin
                     data_n[r*FrameBitsPerRow +: FrameBitsPerRow] = s_data;
                  end
               end
               ptr_n = ptr + PTR_W'(1);
               if (ptr == PTR_W'(NumRows - 1)) begin
                  state_n = discard ? IDLE : SETUP;
               end
            end
         end
         SETUP: begin
            state_n = STROBE;
            cnt_n   = '0;
         end
         STROBE: begin
            if (cnt == CNT_W'(StrobeCycles - 1)) begin
               state_n = HOLD;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         HOLD: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge UserCLK or posedge Reset) begin
      if (Reset) begin
         state     <= IDLE;
         ptr       <= '0;
         cnt       <= '0;
         col       <= '0;
         frm       <= '0;
         discard   <= 1'b0;
         FrameData <= '0;
         err       <= 1'b0;
         s_ready   <= 1'b1;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         ptr       <= ptr_n;
         cnt       <= cnt_n;
         col       <= col_n;
         frm       <= frm_n;
         discard   <= discard_n;
         FrameData <= data_n;
         err       <= err_n;
         s_ready   <= (state_n == IDLE) || (state_n == LOAD);
         busy      <= (state_n != IDLE);
      end
   end

`ifdef CONFIG_FRAME_COUNT_EN
   // Counts frames that reach HOLD; wraps naturally at 16 bits.
   always_ff @(posedge UserCLK or posedge Reset) begin
      if (Reset) begin
         frame_count <= '0;
      end else if (state == STROBE && state_n == HOLD) begin
         frame_count <= frame_count + 16'd1;
      end
   end
`endif

   frame_strobe_decoder #(
      .MaxFramesPerCol (MaxFramesPerCol),
      .NumColumns      (NumColumns)
   ) u_decoder (
      .clk    (UserCLK),
      .rst    (Reset),
      .col    (col),
      .frame  (frm),
      .en     (strobe_en),
      .strobe (FrameStrobe)
   );

endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// Scoreboard bench for frame_strobe_sequencer: driver pushes expected strobes, monitor checks them.
// Frame counter checks are compiled in when CONFIG_FRAME_COUNT_EN is defined.
module tb_frame_strobe_sequencer;

   localparam int unsigned MFC    = 20;
   localparam int unsigned FBR    = 32;
   localparam int unsigned NR     = 4;
   localparam int unsigned NC     = 8;
   localparam int unsigned SC     = 2;
   localparam int unsigned SW     = NC * MFC;
   localparam int unsigned DW     = FBR * NR;
   localparam int unsigned PERIOD = 10;

   typedef struct {
      int unsigned   idx;
      logic [DW-1:0] data;
      time           t_acc;
   } exp_t;

   logic           UserCLK = 1'b0;
   logic           Reset;
   logic [FBR-1:0] s_data;
   logic           s_valid;
   logic           s_ready;
   logic [DW-1:0]  FrameData;
   logic [SW-1:0]  FrameStrobe;
   logic           busy;
   logic           err;
   logic           err_clr;
`ifdef CONFIG_FRAME_COUNT_EN
   logic [15:0]    frame_count;
`endif

   int unsigned    checks = 0;
   int unsigned    errors = 0;
   exp_t           exp_q[$];
   bit             mon_en = 1'b1;
   logic [FBR-1:0] m_rows[NR];
   logic           m_err;
   int unsigned    m_fc;

   frame_strobe_sequencer dut (
      .UserCLK     (UserCLK),
      .Reset       (Reset),
      .s_data      (s_data),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .FrameData   (FrameData),
      .FrameStrobe (FrameStrobe),
      .busy        (busy),
      .err         (err),
`ifdef CONFIG_FRAME_COUNT_EN
      .frame_count (frame_count),
`endif
      .err_clr     (err_clr)
   );

   always #(PERIOD / 2) UserCLK = ~UserCLK;

   task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   function automatic logic [DW-1:0] model_data();
      logic [DW-1:0] d;
      d = '0;
      for (int r = int'(NR) - 1; r >= 0; r--) begin
         d = (d << FBR) | DW'(m_rows[r]);
      end
      return d;
   endfunction

   // Drive one word from a negedge; returns at the negedge after the accepting edge.
   task automatic send_word(input logic [FBR-1:0] w, input int unsigned gap, output time t_acc);
      int unsigned guard;
      s_valid = 1'b0;
      repeat (gap) @(negedge UserCLK);
      s_data  = w;
      s_valid = 1'b1;
      guard   = 0;
      while (!s_ready && guard < 50) begin
         @(negedge UserCLK);
         guard++;
      end
      if (!s_ready) begin
         check("ready_timeout", SW'(s_ready), SW'(1));
      end
      @(posedge UserCLK);
      t_acc = $time;
      @(negedge UserCLK);
      s_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] col, input logic [7:0] frm, input logic [15:0] hi,
                             input logic [FBR-1:0] rows[NR], input int unsigned gap_max, input bit clr);
      time  t;
      bit   bad;
      exp_t e;
      bad     = (32'(col) >= NC) || (32'(frm) >= MFC);
      err_clr = clr;
      send_word({hi, col, frm}, 0, t);
      err_clr = 1'b0;
      m_err   = bad ? 1'b1 : (clr ? 1'b0 : m_err);
      check("err_after_header", SW'(err), SW'(m_err));
      for (int r = 0; r < int'(NR); r++) begin
         send_word(rows[r], $urandom_range(0, gap_max), t);
         if (!bad) m_rows[r] = rows[r];
      end
      if (bad) begin
         check("discard_busy", SW'(busy), SW'(0));
         check("discard_ready", SW'(s_ready), SW'(1));
         check("discard_data_kept", SW'(FrameData), SW'(model_data()));
         check("discard_no_strobe", FrameStrobe, '0);
      end else begin
         e.idx   = 32'(col) * MFC + 32'(frm);
         e.data  = model_data();
         e.t_acc = t;
         exp_q.push_back(e);
         m_fc++;
         check("setup_ready_low", SW'(s_ready), SW'(0));
         check("setup_busy", SW'(busy), SW'(1));
         check("setup_strobe_low", FrameStrobe, '0);
         check("setup_data", SW'(FrameData), SW'(model_data()));
         repeat (SC + 1) @(negedge UserCLK);
         check("hold_ready_low", SW'(s_ready), SW'(0));
         check("hold_strobe_low", FrameStrobe, '0);
         @(negedge UserCLK);
         check("ready_returns", SW'(s_ready), SW'(1));
         check("idle_busy_low", SW'(busy), SW'(0));
      end
   endtask

   // Monitor: every strobe pulse must match the oldest expected frame.
   initial begin : monitor
      exp_t          e;
      logic [SW-1:0] first;
      int unsigned   w;
      forever begin
         @(negedge UserCLK);
         if (mon_en && !Reset && FrameStrobe != '0) begin
            if (exp_q.size() == 0) begin
               check("unexpected_strobe", FrameStrobe, '0);
            end else begin
               e = exp_q.pop_front();
               check("strobe_bit", FrameStrobe, SW'(1) << e.idx);
               check("strobe_data", SW'(FrameData), SW'(e.data));
               check("strobe_latency", SW'($time - e.t_acc), SW'(PERIOD + PERIOD / 2));
               check("strobe_ready_low", SW'(s_ready), '0);
               first = FrameStrobe;
               w     = 1;
               @(negedge UserCLK);
               while (FrameStrobe === first && w < 16) begin
                  w++;
                  @(negedge UserCLK);
               end
               check("strobe_width", SW'(w), SW'(SC));
               check("strobe_release", FrameStrobe, '0);
            end
         end
      end
   end

   initial begin : watchdog
      #(PERIOD * 50000);
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      logic [FBR-1:0] rows[NR];
      logic [7:0]     c, f;
      time            t;
      Reset   = 1'b1;
      s_valid = 1'b0;
      s_data  = '0;
      err_clr = 1'b0;
      m_err   = 1'b0;
      m_fc    = 0;
      for (int r = 0; r < int'(NR); r++) m_rows[r] = '0;
      #(PERIOD + 2);
      check("rst_data", SW'(FrameData), '0);
      check("rst_strobe", FrameStrobe, '0);
      check("rst_busy", SW'(busy), '0);
      check("rst_err", SW'(err), '0);
      check("rst_ready", SW'(s_ready), SW'(1));
`ifdef CONFIG_FRAME_COUNT_EN
      check("rst_frame_count", SW'(frame_count), '0);
`endif
      @(negedge UserCLK);
      Reset = 1'b0;

      rows = '{32'hA, 32'hB, 32'hC, 32'hD};
      send_frame(8'd3, 8'd5, 16'h0000, rows, 0, 1'b0);
      check("t1_frame_data", SW'(FrameData), SW'(128'h0000000D_0000000C_0000000B_0000000A));

      for (int r = 0; r < int'(NR); r++) rows[r] = $urandom;
      send_frame(8'd8, 8'd0, 16'h0000, rows, 0, 1'b0);
      for (int r = 0; r < int'(NR); r++) rows[r] = $urandom;
      send_frame(8'd7, 8'd19, 16'hBEEF, rows, 0, 1'b0);

      for (int r = 0; r < int'(NR); r++) rows[r] = $urandom;
      send_frame(8'd0, 8'd20, 16'h0000, rows, 0, 1'b1);
      err_clr = 1'b1;
      @(negedge UserCLK);
      err_clr = 1'b0;
      m_err   = 1'b0;
      check("err_clr_alone", SW'(err), SW'(m_err));

      for (int r = 0; r < int'(NR); r++) rows[r] = $urandom;
      send_frame(8'd1, 8'd0, 16'h1234, rows, 2, 1'b0);

      for (int i = 0; i < 30; i++) begin
         c = 8'($urandom_range(0, NC + 1));
         f = 8'($urandom_range(0, MFC + 2));
         for (int r = 0; r < int'(NR); r++) rows[r] = $urandom;
         send_frame(c, f, 16'($urandom), rows, $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
      end

      mon_en = 1'b0;
      for (int r = 0; r < int'(NR); r++) rows[r] = $urandom;
      send_word({16'h0000, 8'd4, 8'd7}, 0, t);
      for (int r = 0; r < int'(NR); r++) send_word(rows[r], 0, t);
      @(negedge UserCLK);
      check("t5_strobe_before_reset", FrameStrobe, SW'(1) << (4 * MFC + 7));
      #2 Reset = 1'b1;
      #1;
      check("t5_strobe_async_drop", FrameStrobe, '0);
      check("t5_data_cleared", SW'(FrameData), '0);
      check("t5_busy_cleared", SW'(busy), '0);
      check("t5_ready_set", SW'(s_ready), SW'(1));
      for (int r = 0; r < int'(NR); r++) m_rows[r] = '0;
      m_err = 1'b0;
      m_fc  = 0;
      @(negedge UserCLK);
      Reset  = 1'b0;
      mon_en = 1'b1;
      for (int r = 0; r < int'(NR); r++) rows[r] = $urandom;
      send_frame(8'd6, 8'd11, 16'h0000, rows, 1, 1'b0);

`ifdef CONFIG_FRAME_COUNT_EN
      check("frame_count", SW'(frame_count), SW'(16'(m_fc)));
      force dut.frame_count = 16'hFFFF;
      @(negedge UserCLK);
      release dut.frame_count;
      for (int r = 0; r < int'(NR); r++) rows[r] = $urandom;
      send_frame(8'd2, 8'd2, 16'h0000, rows, 0, 1'b0);
      check("frame_count_wrap", SW'(frame_count), '0);
`endif

      repeat (4) @(negedge UserCLK);
      check("pending_frames", SW'(exp_q.size()), '0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
